// File: rtl/addr_pc_unit.sv
// Address / program-counter datapath stage: owns the PC, the input data latch (DL)
// and the address-bus hold latches, and resolves the ABL, ABH and DB source muxes.
module addr_pc_unit #(
  parameter int unsigned                 DATA_WIDTH = 8,
  parameter logic [2*DATA_WIDTH-1:0]     RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   iodb,
  input  logic [DATA_WIDTH-1:0]   ra_l,
  input  logic [DATA_WIDTH-1:0]   ra_h,
  input  logic                    rw,
  input  logic                    pci,
  input  logic                    pcl_abl,
  input  logic                    pch_abh,
  input  logic                    pcl_db,
  input  logic                    pch_db,
  input  logic                    abl_pcl,
  input  logic                    abh_pch,
  input  logic                    dl_db,
  input  logic                    dl_abl,
  input  logic                    dl_abh,
  input  logic                    ral_adl,
  input  logic                    rah_adh,
  output logic [DATA_WIDTH-1:0]   abl,
  output logic [DATA_WIDTH-1:0]   abh,
  output logic [DATA_WIDTH-1:0]   db_out,
  output logic                    db_oe,
  output logic [2*DATA_WIDTH-1:0] pc,
  output logic                    bus_err
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] dl_q,       dl_d;
  logic [DATA_WIDTH-1:0] abl_hold_q;
  logic [DATA_WIDTH-1:0] abh_hold_q;
  logic                  bus_err_q,  bus_err_d;

  logic [DATA_WIDTH-1:0] pcl, pch;
  logic [DATA_WIDTH-1:0] abl_mux, abh_mux;
  logic [DATA_WIDTH-1:0] next_l, next_h;
  logic                  conflict;

  function automatic logic multi_hot3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign pcl = pc_q[DATA_WIDTH-1:0];
  assign pch = pc_q[PW-1:DATA_WIDTH];

  // NOTE: every always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    abl_mux = abl_hold_q;
    if (pcl_abl)      abl_mux = pcl;
    else if (dl_abl)  abl_mux = dl_q;
    else if (ral_adl) abl_mux = ra_l;
  end

  always_comb begin
    abh_mux = abh_hold_q;
    if (pch_abh)      abh_mux = pch;
    else if (dl_abh)  abh_mux = dl_q;
    else if (rah_adh) abh_mux = ra_h;
  end

  always_comb begin
    db_out = '0;
    if (dl_db)       db_out = dl_q;
    else if (pcl_db) db_out = pcl;
    else if (pch_db) db_out = pch;
  end

  assign db_oe = dl_db | pcl_db | pch_db;

  // PC loads from the muxed address of the same cycle, so a load and an increment
  // together land on the loaded address plus one.
  assign next_l = abl_pcl ? abl_mux : pcl;
  assign next_h = abh_pch ? abh_mux : pch;
  assign pc_d   = {next_h, next_l} + {{(PW-1){1'b0}}, pci};

  assign dl_d = rw ? dl_q : iodb;

  assign conflict = multi_hot3({pcl_abl, dl_abl, ral_adl})
                  | multi_hot3({pch_abh, dl_abh, rah_adh})
                  | multi_hot3({dl_db,   pcl_db, pch_db})
                  | (rw & dl_db);

  assign bus_err_d = bus_err_q | conflict;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      dl_q       <= '0;
      abl_hold_q <= '0;
      abh_hold_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      dl_q       <= dl_d;
      abl_hold_q <= abl_mux;
      abh_hold_q <= abh_mux;
      bus_err_q  <= bus_err_d;
    end
  end

  assign abl     = abl_mux;
  assign abh     = abh_mux;
  assign pc      = pc_q;
  assign bus_err = bus_err_q;

endmodule
